// File: rtl/step_dir_pulse_gen_if.sv
// Step-request handshake between dda_timer (master) and step_dir_pulse_gen (slave).
interface step_dir_pulse_gen_if;
  logic req_valid;
  logic req_dir;
  logic req_ready;

  modport master (
    output req_valid,
    output req_dir,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_dir,
    output req_ready
  );
endinterface

// File: rtl/step_dir_pulse_gen.sv
// STEP/DIR pin waveform generator: enforces DIR-to-STEP setup, minimum STEP high/low
// widths, and tracks a signed position count for an external stepper driver.
module step_dir_pulse_gen #(
  parameter int CNT_W = 10,
  parameter int POS_W = 32
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    enable,
  step_dir_pulse_gen_if.slave     req,
  input  logic [CNT_W-1:0]        setup_cycles,
  input  logic [CNT_W-1:0]        high_cycles,
  input  logic [CNT_W-1:0]        low_cycles,
  input  logic                    pos_clear,
  output logic                    step_out,
  output logic                    dir_out,
  output logic                    busy,
  output logic signed [POS_W-1:0] position
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   s_lat;
  logic [CNT_W-1:0]   h_lat;
  logic [CNT_W-1:0]   l_lat;

  logic               ready;
  logic               accept;
  logic               setup_done;
  logic               need_setup;
  logic               enter_high;
  logic               step_fwd;
  logic [POS_W-1:0]   pos_delta;

  // Phase counter runs 0..max(w,1)-1, so a zero width still lasts one clock.
  function automatic logic [CNT_W-1:0] last_count(input logic [CNT_W-1:0] w);
    return (w == '0) ? '0 : w - CNT_W'(1);
  endfunction

  assign ready         = (state == ST_IDLE) && enable;
  assign req.req_ready = ready;
  assign accept        = req.req_valid && ready;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    need_setup = 1'b0;
    setup_done = 1'b0;
    enter_high = 1'b0;
    step_fwd   = dir_out;
    if (accept) begin
      need_setup = (req.req_dir != dir_out) && (setup_cycles != '0);
      step_fwd   = req.req_dir;
      enter_high = !need_setup;
    end
    if (state == ST_SETUP) begin
      setup_done = (cnt == last_count(s_lat));
      enter_high = setup_done;
    end
  end

  assign pos_delta = step_fwd ? POS_W'(1) : '1;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      s_lat    <= '0;
      h_lat    <= '0;
      l_lat    <= '0;
      step_out <= 1'b0;
      dir_out  <= 1'b0;
      busy     <= 1'b0;
      position <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            s_lat   <= setup_cycles;
            h_lat   <= high_cycles;
            l_lat   <= low_cycles;
            cnt     <= '0;
            busy    <= 1'b1;
            dir_out <= req.req_dir;
            if (need_setup) begin
              state <= ST_SETUP;
            end else begin
              state    <= ST_HIGH;
              step_out <= 1'b1;
            end
          end
        end

        ST_SETUP: begin
          if (setup_done) begin
            state    <= ST_HIGH;
            step_out <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_HIGH: begin
          if (cnt == last_count(h_lat)) begin
            state    <= ST_LOW;
            step_out <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_LOW: begin
          if (cnt == last_count(l_lat)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= ST_IDLE;
          step_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase

      // A clear on the same edge as a STEP rise discards that step.
      if (pos_clear) begin
        position <= '0;
      end else if (enter_high) begin
        position <= position + pos_delta;
      end
    end
  end

endmodule

// File: tb/tb_step_dir_pulse_gen.sv
// Directed bench for step_dir_pulse_gen: timing traces, handshake, position wrap and clear.
module tb_step_dir_pulse_gen;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        enable   = 1'b1;
  logic [9:0]  setup_cycles = '0;
  logic [9:0]  high_cycles  = '0;
  logic [9:0]  low_cycles   = '0;
  logic        pos_clear    = 1'b0;
  logic        step_out, dir_out, busy;
  logic [31:0] position;

  logic        pos_clear4 = 1'b0;
  logic        step_out4, dir_out4, busy4;
  logic [3:0]  position4;

  int tests = 0;
  int fails = 0;

  step_dir_pulse_gen_if req_if ();
  step_dir_pulse_gen_if req4 ();

  step_dir_pulse_gen #(.CNT_W(10), .POS_W(32)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .enable       (enable),
    .req          (req_if),
    .setup_cycles (setup_cycles),
    .high_cycles  (high_cycles),
    .low_cycles   (low_cycles),
    .pos_clear    (pos_clear),
    .step_out     (step_out),
    .dir_out      (dir_out),
    .busy         (busy),
    .position     (position)
  );

  step_dir_pulse_gen #(.CNT_W(10), .POS_W(4)) dut4 (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .enable       (enable),
    .req          (req4),
    .setup_cycles (setup_cycles),
    .high_cycles  (high_cycles),
    .low_cycles   (low_cycles),
    .pos_clear    (pos_clear4),
    .step_out     (step_out4),
    .dir_out      (dir_out4),
    .busy         (busy4),
    .position     (position4)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Accept one request and check the full trace against effective S/H/L widths.
  task automatic run_pulse(input string name, input logic dir, input int s_exp,
                           input int h_exp, input int l_exp,
                           input logic [31:0] pos_before, input logic [31:0] pos_after,
                           input int poke_cycle, input int poke_kind);
    int          waited = 0;
    int          total;
    logic        exp_step;
    logic [31:0] exp_pos;
    while (!req_if.req_ready && waited < 50) begin
      tick();
      waited++;
    end
    tests++;
    if (req_if.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_before: req_ready=%b, required 1", name, req_if.req_ready);
    end
    req_if.req_valid = 1'b1;
    req_if.req_dir   = dir;
    tick();
    req_if.req_valid = 1'b0;
    total = s_exp + h_exp + l_exp;
    for (int c = 1; c <= total; c++) begin
      exp_step = (c > s_exp) && (c <= s_exp + h_exp);
      exp_pos  = (c > s_exp) ? pos_after : pos_before;
      tests++;
      if (step_out !== exp_step) begin
        fails++;
        $display("FAIL %s step c%0d: step_out=%b, required %b", name, c, step_out, exp_step);
      end
      tests++;
      if (dir_out !== dir) begin
        fails++;
        $display("FAIL %s dir c%0d: dir_out=%b, required %b", name, c, dir_out, dir);
      end
      tests++;
      if (busy !== 1'b1 || req_if.req_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s busy c%0d: busy=%b ready=%b, required 1/0", name, c, busy, req_if.req_ready);
      end
      tests++;
      if (position !== exp_pos) begin
        fails++;
        $display("FAIL %s pos c%0d: position=%h, required %h", name, c, position, exp_pos);
      end
      if (c == poke_cycle) begin
        if (poke_kind == 1) enable = 1'b0;
        if (poke_kind == 2) high_cycles = 10'd1;
      end
      tick();
    end
    tests++;
    if (busy !== 1'b0 || req_if.req_ready !== enable) begin
      fails++;
      $display("FAIL %s end: busy=%b ready=%b, required 0/%b", name, busy, req_if.req_ready, enable);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    wb_rst_i = 1'b0;
    tick();
    tests++;
    if (step_out !== 1'b0 || dir_out !== 1'b0 || position !== 32'd0 || busy !== 1'b0 ||
        req_if.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle: step=%b dir=%b pos=%h busy=%b ready=%b, required 0 0 0 0 1",
               step_out, dir_out, position, busy, req_if.req_ready);
    end
    setup_cycles = 10'd0; high_cycles = 10'd5; low_cycles = 10'd1;
    req_if.req_valid = 1'b1;
    req_if.req_dir   = 1'b1;
    tick();
    req_if.req_valid = 1'b0;
    tests++;
    if (step_out !== 1'b1 || dir_out !== 1'b1 || position !== 32'd1) begin
      fails++;
      $display("FAIL reset_pre: step=%b dir=%b pos=%h, required 1 1 1", step_out, dir_out, position);
    end
    tick();
    #3 wb_rst_i = 1'b1;
    #1;
    tests++;
    if (step_out !== 1'b0 || dir_out !== 1'b0 || position !== 32'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: step=%b dir=%b pos=%h busy=%b, required 0 0 0 0",
               step_out, dir_out, position, busy);
    end
    #1 wb_rst_i = 1'b0;
    #1;
    tests++;
    if (req_if.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: req_ready=%b, required 1", req_if.req_ready);
    end
    tick();
  endtask

  task automatic test_single_forward();
    setup_cycles = 10'd4; high_cycles = 10'd3; low_cycles = 10'd2;
    tests++;
    if (dir_out !== 1'b0) begin
      fails++;
      $display("FAIL single_dir_pre: dir_out=%b, required 0", dir_out);
    end
    run_pulse("single_fwd", 1'b1, 4, 3, 2, 32'd0, 32'd1, 0, 0);
  endtask

  task automatic test_back_to_back();
    int   accepts = 0;
    int   rises   = 0;
    int   last_rise = 0;
    int   cyc     = 0;
    logic prev_step = 1'b0;
    setup_cycles = 10'd0; high_cycles = 10'd1; low_cycles = 10'd1;
    pos_clear = 1'b1;
    tick();
    pos_clear = 1'b0;
    tests++;
    if (position !== 32'd0) begin
      fails++;
      $display("FAIL b2b_clear: position=%h, required 0", position);
    end
    req_if.req_valid = 1'b1;
    req_if.req_dir   = 1'b1;
    while (cyc < 200 && !(rises == 10 && accepts == 10 && req_if.req_ready)) begin
      if (req_if.req_valid && req_if.req_ready) accepts++;
      tick();
      cyc++;
      if (accepts == 10) req_if.req_valid = 1'b0;
      if (step_out && !prev_step) begin
        rises++;
        if (rises > 1) begin
          tests++;
          if (cyc - last_rise != 3) begin
            fails++;
            $display("FAIL b2b_period %0d: period=%0d, required 3", rises, cyc - last_rise);
          end
        end
        last_rise = cyc;
      end
      prev_step = step_out;
    end
    req_if.req_valid = 1'b0;
    tests++;
    if (rises != 10 || accepts != 10) begin
      fails++;
      $display("FAIL b2b_count: pulses=%0d accepts=%0d, required 10/10", rises, accepts);
    end
    tests++;
    if (position !== 32'd10) begin
      fails++;
      $display("FAIL b2b_pos: position=%h, required 0000000a", position);
    end
  endtask

  task automatic test_reversal_zero();
    setup_cycles = 10'd0; high_cycles = 10'd0; low_cycles = 10'd0;
    pos_clear = 1'b1;
    tick();
    pos_clear = 1'b0;
    run_pulse("zero_fwd1", 1'b1, 0, 1, 1, 32'd0, 32'd1, 0, 0);
    run_pulse("zero_fwd2", 1'b1, 0, 1, 1, 32'd1, 32'd2, 0, 0);
    run_pulse("zero_rev",  1'b0, 0, 1, 1, 32'd2, 32'd1, 0, 0);
    tests++;
    if (position !== 32'd1) begin
      fails++;
      $display("FAIL zero_pos: position=%h, required 1", position);
    end
  endtask

  task automatic test_mid_pulse();
    setup_cycles = 10'd3; high_cycles = 10'd5; low_cycles = 10'd2;
    run_pulse("drop_enable", 1'b0, 0, 5, 2, 32'd1, 32'd0, 2, 1);
    req_if.req_valid = 1'b1;
    req_if.req_dir   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (busy !== 1'b0 || req_if.req_ready !== 1'b0) begin
        fails++;
        $display("FAIL disabled_hold %0d: busy=%b ready=%b, required 0/0", i, busy, req_if.req_ready);
      end
    end
    req_if.req_valid = 1'b0;
    enable = 1'b1;
    tick();
    high_cycles = 10'd5; low_cycles = 10'd1;
    run_pulse("high_change", 1'b0, 0, 5, 1, 32'd0, 32'hFFFF_FFFF, 2, 2);
    run_pulse("high_next",   1'b0, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
  endtask

  task automatic test_pos_clear_on_step();
    setup_cycles = 10'd0; high_cycles = 10'd2; low_cycles = 10'd1;
    req_if.req_valid = 1'b1;
    req_if.req_dir   = 1'b0;
    pos_clear = 1'b1;
    tick();
    req_if.req_valid = 1'b0;
    pos_clear = 1'b0;
    tests++;
    if (step_out !== 1'b1 || position !== 32'd0) begin
      fails++;
      $display("FAIL clear_on_step: step=%b pos=%h, required 1/0", step_out, position);
    end
    repeat (3) tick();
    tests++;
    if (busy !== 1'b0 || req_if.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL clear_end: busy=%b ready=%b, required 0/1", busy, req_if.req_ready);
    end
    run_pulse("after_clear", 1'b0, 0, 2, 1, 32'd0, 32'hFFFF_FFFF, 0, 0);
  endtask

  task automatic step4(input logic dir);
    int waited = 0;
    while (!req4.req_ready && waited < 20) begin
      tick();
      waited++;
    end
    req4.req_valid = 1'b1;
    req4.req_dir   = dir;
    tick();
    req4.req_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_position_wrap();
    setup_cycles = 10'd0; high_cycles = 10'd0; low_cycles = 10'd0;
    repeat (7) step4(1'b1);
    tests++;
    if (position4 !== 4'h7) begin
      fails++;
      $display("FAIL wrap_pre: position=%h, required 7", position4);
    end
    step4(1'b1);
    tests++;
    if (position4 !== 4'h8) begin
      fails++;
      $display("FAIL wrap_pos: position=%h, required 8", position4);
    end
    pos_clear4 = 1'b1;
    tick();
    pos_clear4 = 1'b0;
    tests++;
    if (position4 !== 4'h0) begin
      fails++;
      $display("FAIL wrap_clear: position=%h, required 0", position4);
    end
    step4(1'b0);
    tests++;
    if (position4 !== 4'hF || dir_out4 !== 1'b0) begin
      fails++;
      $display("FAIL wrap_neg: position=%h dir=%b, required f/0", position4, dir_out4);
    end
    step4(1'b1);
    tests++;
    if (position4 !== 4'h0) begin
      fails++;
      $display("FAIL wrap_up: position=%h, required 0", position4);
    end
  endtask

  initial begin
    req_if.req_valid = 1'b0;
    req_if.req_dir   = 1'b0;
    req4.req_valid   = 1'b0;
    req4.req_dir     = 1'b0;
    test_reset();
    test_single_forward();
    test_back_to_back();
    test_reversal_zero();
    test_mid_pulse();
    test_pos_clear_on_step();
    test_position_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
